// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with configurable width, bit period and frame format
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  d_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic                  wrap;
  assign wrap = pre_q == PW'(PRESCALE - 1);
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    pre_d     = (state_q == IDLE || wrap) ? '0 : pre_q + PW'(1);
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    case (state_q)
      IDLE: if (d_valid) begin
        state_d   = START;
        bit_d     = '0;
        data_d    = p_data;
        par_en_d  = par_en;
        par_typ_d = par_typ;
        stop2_d   = stop2;
      end
      START:  state_d = wrap ? DATA : START;
      DATA: if (wrap) begin
        bit_d   = bit_q == BW'(DATA_WIDTH - 1) ? '0 : bit_q + BW'(1);
        state_d = bit_q != BW'(DATA_WIDTH - 1) ? DATA : par_en_q ? PARITY : STOP1;
      end
      PARITY: state_d = wrap ? STOP1 : PARITY;
      STOP1:  state_d = !wrap ? STOP1 : stop2_q ? STOP2 : IDLE;
      STOP2:  state_d = wrap ? IDLE : STOP2;
      default: begin
        state_d = IDLE;
        pre_d   = '0;
      end
    endcase
  end
  // Outputs decode only registered state, so input changes never reach the line directly.
  always_comb begin
    tx_out     = 1'b1;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      START: begin
        tx_out = 1'b0;
        busy   = 1'b1;
      end
      DATA: begin
        tx_out = data_q[bit_q];
        busy   = 1'b1;
      end
      PARITY: begin
        tx_out = ^data_q ^ par_typ_q;
        busy   = 1'b1;
      end
      STOP1: begin
        busy       = 1'b1;
        frame_done = wrap && !stop2_q;
      end
      STOP2: begin
        busy       = 1'b1;
        frame_done = wrap;
      end
      default: begin
        tx_out     = 1'b1;
        busy       = 1'b0;
        frame_done = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed frame checks on an 8-bit/prescale-1 core and a 5-bit/prescale-4 core
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       rest, va, vb, par_en, par_typ, stop2;
  logic [7:0] pa;
  logic [4:0] pb;
  logic       tx_a, busy_a, fd_a, tx_b, busy_b, fd_b;
  int         total = 0;
  int         bad = 0;
  always #5 clk = ~clk;
  uart_tx_param #(.DATA_WIDTH(8), .PRESCALE(1)) u_a (
    .clk(clk), .rest(rest), .p_data(pa), .d_valid(va), .par_en(par_en), .par_typ(par_typ),
    .stop2(stop2), .tx_out(tx_a), .busy(busy_a), .frame_done(fd_a));
  uart_tx_param #(.DATA_WIDTH(5), .PRESCALE(4)) u_b (
    .clk(clk), .rest(rest), .p_data(pb), .d_valid(vb), .par_en(par_en), .par_typ(par_typ),
    .stop2(stop2), .tx_out(tx_b), .busy(busy_b), .frame_done(fd_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rest = 1'b1; va = 1'b0; vb = 1'b0; pa = '0; pb = '0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    tick(); tick();
    total++;
    if ({tx_a, busy_a, fd_a} !== 3'b100) begin
      bad++; $display("FAIL reset_a got=%b exp=100", {tx_a, busy_a, fd_a});
    end
    total++;
    if ({tx_b, busy_b, fd_b} !== 3'b100) begin
      bad++; $display("FAIL reset_b got=%b exp=100", {tx_b, busy_b, fd_b});
    end
    rest = 1'b0;
    tick();
  endtask

  task automatic test_even_parity(input bit disturb);
    logic [0:10] e = 11'b01010010101;
    pa = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; va = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) va = 1'b0;
      if (disturb && i == 3) begin va = 1'b1; pa = 8'hFF; par_typ = 1'b1; end
      if (disturb && i == 4) va = 1'b0;
      total++;
      if ({tx_a, busy_a, fd_a} !== {e[i], 1'b1, i == 10}) begin
        bad++; $display("FAIL even_a dist=%0d cyc=%0d got=%b exp=%b", disturb, i, {tx_a, busy_a, fd_a}, {e[i], 1'b1, i == 10});
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({tx_a, busy_a, fd_a} !== 3'b100) begin
        bad++; $display("FAIL even_a_idle dist=%0d cyc=%0d got=%b exp=100", disturb, i, {tx_a, busy_a, fd_a});
      end
    end
  endtask

  task automatic test_odd_stop2;
    logic [0:11] e = 12'b011000000111;
    pa = 8'h03; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; va = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) va = 1'b0;
      total++;
      if ({tx_a, busy_a, fd_a} !== {e[i], 1'b1, i == 11}) begin
        bad++; $display("FAIL odd_a cyc=%0d got=%b exp=%b", i, {tx_a, busy_a, fd_a}, {e[i], 1'b1, i == 11});
      end
    end
    tick();
    total++;
    if ({tx_a, busy_a, fd_a} !== 3'b100) begin
      bad++; $display("FAIL odd_a_end got=%b exp=100", {tx_a, busy_a, fd_a});
    end
  endtask

  task automatic test_prescale;
    logic [0:6] e = 7'b0101011;
    pb = 5'h15; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; vb = 1'b1;
    for (int i = 0; i < 28; i++) begin
      tick();
      if (i == 0) vb = 1'b0;
      total++;
      if ({tx_b, busy_b, fd_b} !== {e[i/4], 1'b1, i == 27}) begin
        bad++; $display("FAIL presc_b cyc=%0d got=%b exp=%b", i, {tx_b, busy_b, fd_b}, {e[i/4], 1'b1, i == 27});
      end
    end
    tick();
    total++;
    if ({tx_b, busy_b, fd_b} !== 3'b100) begin
      bad++; $display("FAIL presc_b_end got=%b exp=100", {tx_b, busy_b, fd_b});
    end
  endtask

  task automatic test_back_to_back;
    logic [0:10] e = 11'b01010101011;
    pa = 8'h55; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; va = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 21) va = 1'b0;
      total++;
      if ({tx_a, busy_a, fd_a} !== {e[i%11], i % 11 != 10, i % 11 == 9}) begin
        bad++; $display("FAIL b2b_a cyc=%0d got=%b exp=%b", i, {tx_a, busy_a, fd_a}, {e[i%11], i % 11 != 10, i % 11 == 9});
      end
    end
    tick();
    total++;
    if ({tx_a, busy_a} !== 2'b10) begin
      bad++; $display("FAIL b2b_a_stop got=%b exp=10", {tx_a, busy_a});
    end
  endtask

  task automatic test_mid_reset;
    pa = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; va = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) va = 1'b0;
    end
    total++;
    if ({tx_a, busy_a} !== 2'b01) begin
      bad++; $display("FAIL mid_bit3 got=%b exp=01", {tx_a, busy_a});
    end
    rest = 1'b1;
    tick();
    total++;
    if ({tx_a, busy_a, fd_a} !== 3'b100) begin
      bad++; $display("FAIL mid_reset got=%b exp=100", {tx_a, busy_a, fd_a});
    end
    rest = 1'b0;
    tick();
    total++;
    if ({tx_a, busy_a, fd_a} !== 3'b100) begin
      bad++; $display("FAIL mid_reset_hold got=%b exp=100", {tx_a, busy_a, fd_a});
    end
  endtask

  initial begin
    test_reset();
    test_even_parity(1'b0);
    test_odd_stop2();
    test_prescale();
    test_even_parity(1'b1);
    test_back_to_back();
    test_mid_reset();
    test_even_parity(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Replaces the separate TX FSM, serializer, parity and mux blocks with one core.
- Data width, bits per baud and frame format (parity on/off, even/odd, 1 or 2 stop bits) are configurable.
- Frame config is sampled per frame.
- Sits between the system-side data source (FIFO/register file path) and the UART TX pin, in the UART TX clock domain.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal 5..9
PRESCALE, 1, clk cycles per serial bit; legal >=1 (1 = one bit per clk)

Ports:
clk  input  1  UART TX clock; all logic on rising edge
rest  input  1  synchronous, active-high reset
p_data  input  DATA_WIDTH  parallel payload, sampled on acceptance
d_valid  input  1  request to send p_data
par_en  input  1  1 = parity bit inserted after data
par_typ  input  1  0 = even parity, 1 = odd parity
stop2  input  1  0 = one stop bit, 1 = two stop bits
tx_out  output  1  serial line; idle high
busy  output  1  high while a frame is in progress
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset: clk edge with rest=1 gives state=IDLE, tx_out=1, busy=0, frame_done=0.
  - Prescale counter, bit counter and latched data/config are cleared.
  - Applies mid-frame: the frame is aborted with no partial stop bit, and the line returns high on the same edge.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. All outputs are registered, or decoded from registered state only; no combinational path from inputs to outputs.
- Acceptance:
  - In IDLE with d_valid=1, the edge latches p_data, par_en, par_typ, stop2 and moves to START.
  - The start bit appears on tx_out the cycle after d_valid is sampled (latency 1 clk).
  - d_valid outside IDLE is ignored; input changes mid-frame do not affect the frame.
- Bit timing: each of START/DATA/PARITY/STOP1/STOP2 holds tx_out for exactly PRESCALE cycles. The prescale counter runs 0..PRESCALE-1, and the state advances when it wraps.
- START: tx_out=0.
- DATA: tx_out = latched data[bit_cnt], LSB first. bit_cnt runs 0..DATA_WIDTH-1. After bit DATA_WIDTH-1 the next state is PARITY if par_en, else STOP1.
- PARITY:
  - Even: tx_out = XOR of all latched data bits.
  - Odd: tx_out = inverted XOR.
  - Parity is computed from the latched data, not from live p_data.
- STOP1: tx_out=1. Next state is STOP2 if stop2=1, else IDLE.
- STOP2: tx_out=1, then IDLE.
- busy: 1 in every non-IDLE state, 0 in IDLE, so it goes high the same cycle the start bit begins.
- frame_done: 1 for exactly the final clk of the last stop bit.
- Back-to-back: after a frame the FSM is in IDLE for at least one cycle (busy=0). A d_valid held high is then accepted on that IDLE cycle, so the minimum inter-frame gap is one idle-high clk.
- Frame length in clk cycles = PRESCALE*(1 + DATA_WIDTH + par_en + 1 + stop2).
- Illegal/unreachable state encodings return to IDLE with idle outputs.
- Counter widths: prescale counter = max(1, clog2(PRESCALE)); bit counter = clog2(DATA_WIDTH).

Test Plan:
1. DATA_WIDTH=8, PRESCALE=1, 0xA5, par_en=1, par_typ=0, stop2=0 -> tx_out 0,1,0,1,0,0,1,0,1,0,1 starting 1 clk after d_valid. busy high 11 cycles. frame_done on cycle 11.
2. Same params, 0x03, par_en=1, par_typ=1, stop2=1 -> 0,1,1,0,0,0,0,0,0,1,1,1. Odd parity bit = 1. 12 cycles busy.
3. DATA_WIDTH=5, PRESCALE=4, 0x15, par_en=0, stop2=0 -> bits 0,1,0,1,0,1,1, each held 4 clks. busy 28 cycles. frame_done once.
4. During case 1 frame, pulse d_valid with p_data=0xFF and toggle par_typ -> frame unchanged. No second frame unless d_valid is high in IDLE.
5. d_valid held high continuously with 0x55, PRESCALE=1, no parity -> consecutive frames separated by exactly one IDLE cycle (tx_out=1, busy=0).
6. Assert rest during DATA bit 3 of 0xA5 -> next edge tx_out=1, busy=0, frame_done=0. A new d_valid then sends a complete correct frame.
